register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 137 +++++++++++++
 tb/tb_register_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file -- RISC-V style integer register file, 2 read / 1 write ports.
//
// Register 0 is hardwired to zero (x0). Reads are purely combinational; the
// single write port commits on the rising clock edge. Addresses at or above
// REG_COUNT are treated as non-existent registers: writes are dropped and
// reads return zero.
//
// Optional build macro:
//   REGFILE_BYPASS_EN  -- when defined, a read whose address matches an
//                         in-flight legal write returns WD3 combinationally
//                         (write-to-read forwarding). Undefined by default.
//
// Parameters:
//   DATA_WIDTH  register / data port width
//   ADDR_WIDTH  address port width
//   REG_COUNT   number of architectural registers (2 .. 2**ADDR_WIDTH)
//
// Ports:
//   clk   in   clock, writes on rising edge
//   rst   in   asynchronous active-low reset, clears all registers
//   WE3   in   write enable
//   WD3   in   write data
//   A1    in   read address, port 1
//   A2    in   read address, port 2
//   A3    in   write address
//   RD1   out  read data, port 1
//   RD2   out  read data, port 2
// -----------------------------------------------------------------------------

// One storage register. Reset is asynchronous so every register clears the
// moment rst falls, regardless of clock activity.
module regfile_cell #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // An X/Z enable falls to the hold branch, so an unknown WE3 never
    // corrupts stored state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:1]  wr_sel;
    logic [REG_COUNT-1:1]  wr_en;
    logic [DATA_WIDTH-1:0] rd1_raw;
    logic [DATA_WIDTH-1:0] rd2_raw;

    // x0 has no storage; it always reads as zero.
    assign regs[0] = '0;

    // Only registers 1..REG_COUNT-1 are decoded, so A3 == 0 or A3 beyond
    // the register count matches nothing and the write is dropped.
    generate
        for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
            assign wr_sel[i] = (A3 == ADDR_WIDTH'(i));
            assign wr_en[i]  = WE3 & rst & wr_sel[i];

            regfile_cell #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_cell (
                .clk(clk),
                .rst(rst),
                .en (wr_en[i]),
                .d  (WD3),
                .q  (regs[i])
            );
        end
    endgenerate

    // Read mux by compare rather than direct indexing: an address beyond
    // REG_COUNT matches no entry and the default zero comes through.
    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (A1 == ADDR_WIDTH'(i))
                rd1_raw = regs[i];
            if (A2 == ADDR_WIDTH'(i))
                rd2_raw = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic a3_legal;

    // wr_sel only covers 1..REG_COUNT-1, so this excludes x0 and
    // out-of-range targets from forwarding as well.
    assign a3_legal = |wr_sel;

    // if() with an unknown condition takes the default path, so X on WE3
    // forwards nothing.
    always_comb begin
        RD1 = rd1_raw;
        RD2 = rd2_raw;
        if (WE3 && rst && a3_legal) begin
            if (A1 == A3)
                RD1 = WD3;
            if (A2 == A3)
                RD2 = WD3;
        end
    end
`else
    // No forwarding: reads show stored contents only, the new value
    // appears after the write edge.
    assign RD1 = rd1_raw;
    assign RD2 = rd2_raw;
`endif

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file -- directed self-checking bench for register_file.
// A default 32-entry instance covers the main function; a second instance with
// REG_COUNT=16 covers out-of-range addresses. Expected values go into a
// scoreboard queue as stimulus is driven and are popped when outputs settle.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        WE3 = 1'b0;
    logic [31:0] WD3 = '0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
    logic [31:0] RD1, RD2;

    logic        WE3b = 1'b0;
    logic [31:0] WD3b = '0;
    logic [4:0]  A1b = '0, A2b = '0, A3b = '0;
    logic [31:0] RD1b, RD2b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    register_file dut (
        .clk(clk), .rst(rst), .WE3(WE3), .WD3(WD3),
        .A1(A1), .A2(A2), .A3(A3), .RD1(RD1), .RD2(RD2)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(16)) dut16 (
        .clk(clk), .rst(rst), .WE3(WE3b), .WD3(WD3b),
        .A1(A1b), .A2(A2b), .A3(A3b), .RD1(RD1b), .RD2(RD2b)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Drive both read addresses of the main instance and check both ports.
    task automatic rd(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] e1, input logic [31:0] e2);
        A1 = a1;
        A2 = a2;
        push($sformatf("rd1[%0d]", a1), e1);
        push($sformatf("rd2[%0d]", a2), e2);
        #1;
        pop_check(RD1);
        pop_check(RD2);
    endtask

    task automatic rd16(input logic [4:0] a1, input logic [4:0] a2,
                        input logic [31:0] e1, input logic [31:0] e2);
        A1b = a1;
        A2b = a2;
        push($sformatf("rc16_rd1[%0d]", a1), e1);
        push($sformatf("rc16_rd2[%0d]", a2), e2);
        #1;
        pop_check(RD1b);
        pop_check(RD2b);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        WE3 = 1'b1;
        A3  = a;
        WD3 = d;
        @(negedge clk);
        WE3 = 1'b0;
    endtask

    initial begin
        logic [31:0] pre_exp;

        // Reset state, rst held low
        #1;
        rd(5'd3, 5'd31, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Sweep reads after reset, A1 = A2
        for (int i = 0; i < 32; i++)
            rd(5'(i), 5'(i), 32'h0, 32'h0);

        // Write i to register i, including x0
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            WE3 = 1'b1;
            A3  = 5'(i);
            WD3 = 32'(i);
        end
        @(negedge clk);
        WE3 = 1'b0;
        for (int i = 0; i < 32; i++)
            rd(5'(i), 5'(31 - i), 32'(i), 32'(31 - i));

        // WE3 = 0 leaves contents unchanged
        wr(5'd5, 32'hDEADBEEF);
        WE3 = 1'b0;
        A3  = 5'd5;
        WD3 = 32'h12345678;
        @(negedge clk);
        rd(5'd5, 5'd6, 32'hDEADBEEF, 32'h6);

        // Asynchronous reset mid-cycle, write dropped while low
        wr(5'd7, 32'hA5A5A5A5);
        rd(5'd7, 5'd3, 32'hA5A5A5A5, 32'h3);
        #1 rst = 1'b0;
        rd(5'd7, 5'd3, 32'h0, 32'h0);
        WE3 = 1'b1;
        A3  = 5'd7;
        WD3 = 32'h11;
        @(posedge clk);
        #1;
        rd(5'd7, 5'd5, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        WD3 = 32'h22;
        @(posedge clk);
        #1;
        rd(5'd7, 5'd7, 32'h22, 32'h22);
        @(negedge clk);
        WE3 = 1'b0;

        // Write/read same register across the edge
`ifdef REGFILE_BYPASS_EN
        pre_exp = 32'h55;
`else
        pre_exp = 32'h0;
`endif
        WE3 = 1'b1;
        A3  = 5'd9;
        WD3 = 32'h55;
        rd(5'd9, 5'd9, pre_exp, pre_exp);
        @(posedge clk);
        #1;
        rd(5'd9, 5'd9, 32'h55, 32'h55);
        @(negedge clk);
        WE3 = 1'b0;

        // Unknown write enable must not write
        WE3 = 1'bx;
        A3  = 5'd4;
        WD3 = 32'hFFFFFFFF;
        @(negedge clk);
        WE3 = 1'b0;
        rd(5'd4, 5'd9, 32'h0, 32'h55);

        // Write to x0 is ignored
        wr(5'd0, 32'hCAFEF00D);
        rd(5'd0, 5'd0, 32'h0, 32'h0);

        // REG_COUNT = 16: out-of-range write dropped, no aliasing onto x4
        @(negedge clk);
        WE3b = 1'b1;
        A3b  = 5'd20;
        WD3b = 32'h1;
        @(negedge clk);
        WE3b = 1'b0;
        rd16(5'd20, 5'd4, 32'h0, 32'h0);
        WE3b = 1'b1;
        A3b  = 5'd4;
        WD3b = 32'h77;
        @(negedge clk);
        WE3b = 1'b0;
        rd16(5'd4, 5'd20, 32'h77, 32'h0);
        rd16(5'd15, 5'd16, 32'h0, 32'h0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
